// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: datapath widths, MEM-stage
// state encoding and a small alignment helper.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // MEM-stage controller states, kept as plain constants so older stages
  // that compare raw state bits keep working.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  // A data-memory access must target a whole 32-bit word.
  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the MEM stage: cleared while idle, counts cycles
// spent waiting for dmem_ack and flags when the wait budget is used up.
module mem_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [CNT_W-1:0] count;

  // Cycle counter; clear wins over enable.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage pipeline. Issues loads/stores on a req/ack data
// port, stalls upstream while a transaction is outstanding, and drives the
// mem_wb_* register consumed by writeback.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_mem_readmem,
  input  logic              ex_mem_writemem,
  input  logic [DATA_W-1:0] ex_mem_regb,
  input  logic              ex_mem_selwsource,
  input  logic [REG_W-1:0]  ex_mem_regdest,
  input  logic              ex_mem_writereg,
  input  logic [DATA_W-1:0] ex_mem_wbvalue,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_rd,
  output logic              dmem_wr,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [REG_W-1:0]  mem_wb_regdest,
  output logic              mem_wb_writereg,
  output logic [DATA_W-1:0] mem_wb_wbvalue
);

  logic [0:0]       state;
  logic             access;
  logic             aligned;
  logic             timeout;
  logic [REG_W-1:0] lat_regdest;
  logic             lat_writereg;
  logic             lat_selwsource;

  assign access  = ex_mem_readmem | ex_mem_writemem;
  assign aligned = word_aligned(ex_mem_wbvalue[1:0]);

  // Counts WAIT cycles without an ack; held at zero outside WAIT.
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .enable  ((state == ST_WAIT) && !dmem_ack),
    .timeout (timeout)
  );

  // Upstream hold: raised on accepting an aligned access and through WAIT,
  // dropped in the cycle the transaction completes or aborts.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      ST_IDLE: mem_stall = access && aligned;
      ST_WAIT: mem_stall = !dmem_ack && !timeout;
      default: mem_stall = 1'b0;
    endcase
  end

  // Transaction controller, dmem request registers and mem_wb register.
  // dmem_addr doubles as the latched wbvalue and dmem_rd as the latched op
  // type: both stay valid until the edge that retires the transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      dmem_rd         <= 1'b0;
      dmem_wr         <= 1'b0;
      mem_err         <= 1'b0;
      mem_wb_regdest  <= '0;
      mem_wb_writereg <= 1'b0;
      mem_wb_wbvalue  <= '0;
      lat_regdest     <= '0;
      lat_writereg    <= 1'b0;
      lat_selwsource  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!access) begin
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
            mem_wb_wbvalue  <= ex_mem_wbvalue;
          end else begin
            mem_wb_writereg <= 1'b0;
            if (!aligned) begin
              // Misaligned access retires as a bubble with no request.
              mem_err <= 1'b1;
            end else begin
              state          <= ST_WAIT;
              dmem_addr      <= ex_mem_wbvalue;
              dmem_wdata     <= ex_mem_regb;
              // A combined read+write is flagged and executed as a read.
              dmem_rd        <= ex_mem_readmem;
              dmem_wr        <= ex_mem_writemem & ~ex_mem_readmem;
              lat_regdest    <= ex_mem_regdest;
              lat_writereg   <= ex_mem_writereg;
              lat_selwsource <= ex_mem_selwsource;
              if (ex_mem_readmem && ex_mem_writemem) begin
                mem_err <= 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            state           <= ST_IDLE;
            dmem_rd         <= 1'b0;
            dmem_wr         <= 1'b0;
            mem_wb_regdest  <= lat_regdest;
            mem_wb_writereg <= lat_writereg;
            mem_wb_wbvalue  <= (lat_selwsource && dmem_rd) ? dmem_rdata : dmem_addr;
          end else if (timeout) begin
            state           <= ST_IDLE;
            dmem_rd         <= 1'b0;
            dmem_wr         <= 1'b0;
            mem_err         <= 1'b1;
            mem_wb_writereg <= 1'b0;
          end else begin
            mem_wb_writereg <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table of pipeline instructions with
// expected writeback results queued in a scoreboard, plus hand-written
// sequences for timeout, late ack and reset during a transaction.
module tb_memory_stage;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_mem_readmem = 1'b0;
  logic        ex_mem_writemem = 1'b0;
  logic [31:0] ex_mem_regb = '0;
  logic        ex_mem_selwsource = 1'b0;
  logic [4:0]  ex_mem_regdest = '0;
  logic        ex_mem_writereg = 1'b0;
  logic [31:0] ex_mem_wbvalue = '0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        mem_stall;
  logic        mem_err;
  logic [4:0]  mem_wb_regdest;
  logic        mem_wb_writereg;
  logic [31:0] mem_wb_wbvalue;

  memory_stage #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .ex_mem_readmem    (ex_mem_readmem),
    .ex_mem_writemem   (ex_mem_writemem),
    .ex_mem_regb       (ex_mem_regb),
    .ex_mem_selwsource (ex_mem_selwsource),
    .ex_mem_regdest    (ex_mem_regdest),
    .ex_mem_writereg   (ex_mem_writereg),
    .ex_mem_wbvalue    (ex_mem_wbvalue),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rd           (dmem_rd),
    .dmem_wr           (dmem_wr),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .mem_stall         (mem_stall),
    .mem_err           (mem_err),
    .mem_wb_regdest    (mem_wb_regdest),
    .mem_wb_writereg   (mem_wb_writereg),
    .mem_wb_wbvalue    (mem_wb_wbvalue)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        readmem;
    logic        writemem;
    logic [31:0] regb;
    logic        selwsource;
    logic [4:0]  regdest;
    logic        writereg;
    logic [31:0] wbvalue;
  } instr_t;

  // full = 0 marks a bubble: only writereg (= 0) is defined.
  typedef struct packed {
    logic        full;
    logic [4:0]  regdest;
    logic        writereg;
    logic [31:0] wbvalue;
  } exp_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] rdata;
    int          ack_after;   // WAIT cycle that gets the ack; 0 = no mem op; -1 = never
    int          exp_stall;   // cycles mem_stall is expected high
    exp_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_errs   = 0;
  logic err_model = 1'b0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk_ins(input logic rd, input logic wr, input logic [31:0] regb,
                                    input logic selw, input logic [4:0] rdst,
                                    input logic wreg, input logic [31:0] wbv);
    instr_t i;
    i.readmem = rd;  i.writemem = wr;  i.regb = regb;  i.selwsource = selw;
    i.regdest = rdst; i.writereg = wreg; i.wbvalue = wbv;
    return i;
  endfunction

  function automatic exp_t mk_exp(input logic full, input logic [4:0] rdst,
                                  input logic wreg, input logic [31:0] wbv);
    exp_t e;
    e.full = full; e.regdest = rdst; e.writereg = wreg; e.wbvalue = wbv;
    return e;
  endfunction

  task automatic apply(input instr_t i);
    ex_mem_readmem    = i.readmem;
    ex_mem_writemem   = i.writemem;
    ex_mem_regb       = i.regb;
    ex_mem_selwsource = i.selwsource;
    ex_mem_regdest    = i.regdest;
    ex_mem_writereg   = i.writereg;
    ex_mem_wbvalue    = i.wbvalue;
  endtask

  // Drive one instruction from a negedge, act as the memory while it is
  // stalled, then compare the retired mem_wb_* against the scoreboard.
  // Returns at a negedge with a NOP on the ex_mem_* inputs.
  task automatic issue(input instr_t ins, input logic [31:0] rdata, input int ack_after,
                       input int exp_stall, input exp_t exp, input string tag);
    int   stall_n = 0;
    int   wait_n  = 0;
    exp_t e;
    apply(ins);
    sb.push_back(exp);
    if (ins.readmem || ins.writemem) begin
      if (ins.wbvalue[1:0] != 2'b00 || (ins.readmem && ins.writemem) || ack_after < 0)
        err_model = 1'b1;
    end
    forever begin
      #1;
      if (!mem_stall) break;
      stall_n++;
      if (stall_n > 40) begin
        n_checks++;
        n_errs++;
        $display("FAIL %s stall_bound: got >40 stall cycles expected %0d", tag, exp_stall);
        break;
      end
      @(posedge clock);
      @(negedge clock);
      dmem_ack = 1'b0;
      check({tag, " wb_bubble_in_stall"}, 32'(mem_wb_writereg), 32'd0);
      if (dmem_rd || dmem_wr) begin
        wait_n++;
        check({tag, " dmem_addr"}, dmem_addr, ins.wbvalue);
        check({tag, " dmem_rd"}, 32'(dmem_rd), 32'(ins.readmem));
        check({tag, " dmem_wr"}, 32'(dmem_wr), 32'(ins.writemem & ~ins.readmem));
        if (ins.writemem && !ins.readmem)
          check({tag, " dmem_wdata"}, dmem_wdata, ins.regb);
        if (wait_n == ack_after) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
      end
    end
    check({tag, " stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    @(posedge clock);
    @(negedge clock);
    dmem_ack = 1'b0;
    apply(mk_ins(0, 0, 0, 0, 0, 0, 0));
    e = sb.pop_front();
    check({tag, " mem_wb_writereg"}, 32'(mem_wb_writereg), 32'(e.writereg));
    if (e.full) begin
      check({tag, " mem_wb_regdest"}, 32'(mem_wb_regdest), 32'(e.regdest));
      check({tag, " mem_wb_wbvalue"}, mem_wb_wbvalue, e.wbvalue);
    end
    check({tag, " mem_err"}, 32'(mem_err), 32'(err_model));
    check({tag, " dmem_rd_idle"}, 32'(dmem_rd), 32'd0);
    check({tag, " dmem_wr_idle"}, 32'(dmem_wr), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dmem_addr"}, dmem_addr, 32'd0);
    check({tag, " dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, " dmem_rd"}, 32'(dmem_rd), 32'd0);
    check({tag, " dmem_wr"}, 32'(dmem_wr), 32'd0);
    check({tag, " mem_err"}, 32'(mem_err), 32'd0);
    check({tag, " mem_wb_regdest"}, 32'(mem_wb_regdest), 32'd0);
    check({tag, " mem_wb_writereg"}, 32'(mem_wb_writereg), 32'd0);
    check({tag, " mem_wb_wbvalue"}, mem_wb_wbvalue, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{mk_ins(0, 0, 32'h0, 0, 5'd7, 1, 32'h1234_5678), 32'h0, 0, 0,
                mk_exp(1, 5'd7, 1, 32'h1234_5678)};
    vecs[1] = '{mk_ins(0, 0, 32'h0, 0, 5'd20, 0, 32'hFFFF_FFFF), 32'h0, 0, 0,
                mk_exp(1, 5'd20, 0, 32'hFFFF_FFFF)};
    vecs[2] = '{mk_ins(1, 0, 32'h0, 1, 5'd9, 1, 32'h0000_0100), 32'hDEAD_BEEF, 3, 3,
                mk_exp(1, 5'd9, 1, 32'hDEAD_BEEF)};
    vecs[3] = '{mk_ins(0, 1, 32'hA5A5_A5A5, 0, 5'd3, 0, 32'h0000_0040), 32'h0, 1, 1,
                mk_exp(1, 5'd3, 0, 32'h0000_0040)};
    vecs[4] = '{mk_ins(1, 0, 32'h0, 0, 5'd12, 1, 32'h0000_0200), 32'h0000_0055, 2, 2,
                mk_exp(1, 5'd12, 1, 32'h0000_0200)};
    vecs[5] = '{mk_ins(0, 1, 32'h1357_9BDF, 1, 5'd4, 1, 32'h0000_0044), 32'hFFFF_0000, 1, 1,
                mk_exp(1, 5'd4, 1, 32'h0000_0044)};
    vecs[6] = '{mk_ins(0, 0, 32'h0, 0, 5'd31, 1, 32'h8000_0001), 32'h0, 0, 0,
                mk_exp(1, 5'd31, 1, 32'h8000_0001)};

    // Asynchronous reset at start-up.
    #1 reset = 1'b0;
    #2;
    check_reset_outputs("reset");
    check("reset mem_stall", 32'(mem_stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Table: pass-through, loads and stores with various ack latencies.
    for (int i = 0; i < 7; i++)
      issue(vecs[i].ins, vecs[i].rdata, vecs[i].ack_after, vecs[i].exp_stall,
            vecs[i].exp, $sformatf("vec%0d", i));

    // Timeout: no ack, abort after TIMEOUT stalled WAIT cycles.
    issue(mk_ins(1, 0, 32'h0, 1, 5'd8, 1, 32'h0000_0300), 32'h0, -1, TIMEOUT + 1,
          mk_exp(0, 5'd0, 0, 32'h0), "timeout");

    // Late ack in IDLE must be ignored.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBADB_AD00;
    #1;
    check("late_ack mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clock);
    @(negedge clock);
    dmem_ack = 1'b0;
    check("late_ack dmem_rd", 32'(dmem_rd), 32'd0);
    check("late_ack mem_wb_writereg", 32'(mem_wb_writereg), 32'd0);
    check("late_ack mem_wb_wbvalue", mem_wb_wbvalue, 32'd0);
    check("late_ack mem_err", 32'(mem_err), 32'd1);

    issue(mk_ins(0, 0, 32'h0, 0, 5'd2, 1, 32'h0BAD_F00D), 32'h0, 0, 0,
          mk_exp(1, 5'd2, 1, 32'h0BAD_F00D), "after_timeout_alu");
    issue(mk_ins(1, 0, 32'h0, 1, 5'd11, 1, 32'h0000_0010), 32'h7777_8888, 2, 2,
          mk_exp(1, 5'd11, 1, 32'h7777_8888), "after_timeout_load");

    // Reset asserted while a load is waiting.
    apply(mk_ins(1, 0, 32'h0, 1, 5'd10, 1, 32'h0000_0400));
    @(posedge clock);
    @(negedge clock);
    check("midwait dmem_rd", 32'(dmem_rd), 32'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    apply(mk_ins(0, 0, 0, 0, 0, 0, 0));
    #1;
    check("midwait_reset mem_stall", 32'(mem_stall), 32'd0);
    @(negedge clock);
    reset     = 1'b1;
    err_model = 1'b0;
    issue(mk_ins(1, 0, 32'h0, 1, 5'd13, 1, 32'h0000_0404), 32'h0123_4567, 1, 1,
          mk_exp(1, 5'd13, 1, 32'h0123_4567), "post_reset_load");

    // Read and write together: flagged, executed as a read only.
    issue(mk_ins(1, 1, 32'h1111_1111, 1, 5'd6, 1, 32'h0000_0080), 32'hCAFE_F00D, 1, 1,
          mk_exp(1, 5'd6, 1, 32'hCAFE_F00D), "rd_and_wr");

    // Fresh reset, then misaligned accesses retire as bubbles with no stall.
    @(posedge clock);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    err_model = 1'b0;
    @(negedge clock);
    issue(mk_ins(1, 0, 32'h0, 1, 5'd5, 1, 32'h0000_0102), 32'h0, 0, 0,
          mk_exp(0, 5'd0, 0, 32'h0), "misaligned_load");
    issue(mk_ins(0, 0, 32'h0, 0, 5'd1, 1, 32'hAAAA_5555), 32'h0, 0, 0,
          mk_exp(1, 5'd1, 1, 32'hAAAA_5555), "after_misaligned_alu");
    issue(mk_ins(0, 1, 32'h2222_2222, 0, 5'd14, 0, 32'h0000_0041), 32'h0, 0, 0,
          mk_exp(0, 5'd0, 0, 32'h0), "misaligned_store");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the ex_mem_* pipeline register from the execute stage.
- Runs load/store transactions on the data-memory port using a req/ack handshake with variable latency.
- Stalls upstream while a transaction is outstanding.
- Drives the mem_wb_* pipeline register that feeds writeback.

Parameters:
- TIMEOUT, 255: max cycles in WAIT without mem_ack before abort.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_mem_readmem  in  1  load
- ex_mem_writemem  in  1  store
- ex_mem_regb  in  32  store data
- ex_mem_selwsource  in  1  1 = writeback from memory data, 0 = from wbvalue
- ex_mem_regdest  in  5  destination register
- ex_mem_writereg  in  1  register write enable
- ex_mem_wbvalue  in  32  ALU/shift result; also the memory address
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_rd  out  1  read request
- dmem_wr  out  1  write request
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  transaction complete
- mem_stall  out  1  upstream must hold ex_mem_* and the PC
- mem_err  out  1  sticky error (misaligned, rd+wr together, timeout)
- mem_wb_regdest  out  5
- mem_wb_writereg  out  1
- mem_wb_wbvalue  out  32

Behaviour:
- Reset (async, reset=0): state IDLE, counter 0, all dmem_* and mem_wb_* outputs 0, mem_err 0. A transaction in flight is dropped; a late dmem_ack is ignored.
- States: IDLE, WAIT.
- Access = ex_mem_readmem | ex_mem_writemem.
- IDLE, no access:
  - Next edge: mem_wb_regdest/writereg/wbvalue <= ex_mem_* values. Latency 1.
  - mem_stall = 0.
- IDLE, access, address aligned (wbvalue[1:0] == 0):
  - mem_stall = 1 combinationally.
  - Next edge: latch address, wdata, regdest, writereg, selwsource, and op type; assert dmem_rd or dmem_wr (registered); counter <= 0; go to WAIT.
  - mem_wb_writereg <= 0 (bubble).
- IDLE, access, misaligned:
  - No dmem request.
  - Next edge: mem_err <= 1; mem_wb_writereg <= 0.
  - mem_stall = 0; the instruction is retired as a bubble.
- readmem and writemem both 1: mem_err <= 1; treat as a read only (the write is suppressed).
- WAIT, dmem_ack = 0:
  - mem_stall = 1; counter increments; mem_wb_writereg <= 0 each edge.
  - dmem_addr, dmem_wdata, dmem_rd, dmem_wr held stable.
- WAIT, dmem_ack = 1 (ack may arrive as early as the first WAIT cycle):
  - mem_stall = 0 in that cycle, so upstream advances at the same edge.
  - Next edge: mem_wb_wbvalue <= dmem_rdata if latched selwsource = 1 and op is a read, else the latched wbvalue. mem_wb_regdest and mem_wb_writereg <= latched values.
  - dmem_rd/dmem_wr <= 0; go to IDLE.
- Minimum memory-op occupancy: 2 cycles (accept + WAIT with ack).
- WAIT, counter == TIMEOUT without ack:
  - Abort: drop the request, mem_err <= 1, mem_wb_writereg <= 0, go to IDLE.
  - mem_stall = 0 in that cycle.
- dmem_ack while in IDLE: ignored.
- mem_err clears only on reset.
- Upstream holds ex_mem_* stable whenever mem_stall = 1. The block does not re-sample ex_mem_* in WAIT.

Decomposition:
- Shared package (pipeline_pkg): state encoding (ST_IDLE, ST_WAIT), DATA_W = 32, REG_W = 5.
- Optional sub-module mem_wait_timer: counter with clear/enable and a timeout flag, parameterised by TIMEOUT and CNT_W.
- All other logic stays in memory_stage.

Test Plan:
- ALU pass-through: writereg = 1, regdest = 5'd7, wbvalue = 32'h1234_5678, no mem op -> one edge later mem_wb_* = {7, 1, 32'h1234_5678}; mem_stall never high.
- Load with 3-cycle ack: readmem = 1, selwsource = 1, wbvalue = 32'h100, rdata = 32'hDEAD_BEEF -> dmem_rd = 1 with addr 32'h100; mem_stall high for accept + 2 WAIT cycles; mem_wb_wbvalue = 32'hDEAD_BEEF; mem_wb_writereg = 0 during the stall.
- Store with ack on the first WAIT cycle: writemem = 1, regb = 32'hA5A5_A5A5, wbvalue = 32'h40 -> dmem_wr = 1 for exactly 1 cycle; stall lasts 1 cycle; mem_wb_writereg follows the latched writereg (0 for a store).
- Misaligned load at wbvalue = 32'h102 -> no dmem_rd; mem_err = 1; bubble; no stall.
- Timeout (TIMEOUT = 4), no ack -> abort after 4 WAIT cycles; mem_err = 1; a late ack is ignored and the next instruction proceeds normally.
- Reset asserted mid-WAIT -> all outputs 0 immediately (asynchronous); after reset release, state is IDLE and a subsequent load completes normally.
